// File: rtl/ram_pkg.sv
// Shared constants for the sp_ram family: read-during-write policy codes,
// byte-lane width and the clear-sequencer state encoding.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int LANE_W  = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, requesting a
// zero write per cycle, and holds busy high until the last word is done.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // Clear walk: reset parks at word 0, each cycle advances, leave after the top word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == LAST_ADDR) begin
        state <= ST_IDLE;
      end
    end
  end

  assign busy     = (CLEAR_ON_RST != 0) && (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/sp_ram_sync_be.sv
// Single-port synchronous RAM with per-byte write enables, selectable
// read-during-write policy, optional output register and a post-reset
// clear sequencer that shares the single array write port.
module sp_ram_sync_be
  import ram_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int NB          = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [NB-1:0]     be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              user_wr;
  logic              user_rd;
  logic [NB-1:0]     lane_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_next;

  logic [DATA_W-1:0] data1;
  logic              valid1;

  ram_clear_seq #(
    .ADDR_W       (ADDR_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign user_wr = cs && wr && !busy;
  assign user_rd = cs && rd && !busy;

  // Write-port arbitration: the clear sequencer owns every lane while busy.
  always_comb begin
    lane_we   = '0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (busy) begin
      lane_we   = {NB{clr_we}};
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (user_wr) begin
      lane_we = be;
    end
  end

  // Byte-lane array write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) begin
        mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read value selection: stored word, or stored word merged with enabled write lanes.
  always_comb begin
    old_word    = mem[addr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        merged_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
      end
    end
    rd_next = ((RDW_MODE == RDW_NEW) && user_wr) ? merged_word : old_word;
  end

  // First read stage: capture on accepted reads only so the data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1  <= '0;
      valid1 <= 1'b0;
    end else begin
      valid1 <= user_rd;
      if (user_rd) begin
        data1 <= rd_next;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] data2;
    logic              valid2;

    // Optional output stage: forwards a result one cycle later, holding between results.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data2  <= '0;
        valid2 <= 1'b0;
      end else begin
        valid2 <= valid1;
        if (valid1) begin
          data2 <= data1;
        end
      end
    end

    assign rdata  = data2;
    assign rvalid = valid2;
  end else begin : g_no_out_reg
    assign rdata  = data1;
    assign rvalid = valid1;
  end

endmodule

// File: tb/tb_sp_ram_sync_be.sv
// Self-checking bench for sp_ram_sync_be: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// word-array reference model with a queue of pending read results.
module tb_sp_ram_sync_be #(
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
);

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT    = 1 + OUT_REG;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              rd;
  logic              wr;
  logic [NB-1:0]     be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;

  int n_compared = 0;
  int n_mismatch = 0;
  bit started    = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } pend_t;

  logic [DATA_W-1:0] model_mem [DEPTH];
  pend_t             pend_q [$];
  int                clear_left;
  int                cyc;
  logic [DATA_W-1:0] exp_rdata;
  logic              exp_rvalid;
  logic              exp_busy;

  sp_ram_sync_be #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RDW_MODE     (RDW_MODE),
    .OUT_REG      (OUT_REG),
    .CLEAR_ON_RST (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .rd     (rd),
    .wr     (wr),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic w,
                               input logic [NB-1:0] b, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
    cs    = c;
    rd    = r;
    wr    = w;
    be    = b;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  task automatic setIdle();
    cs = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [NB-1:0] b);
    applyStimulus(1'b1, 1'b0, 1'b1, b, a, d);
    setIdle();
  endtask

  task automatic readCheck(input string name, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, a, '0);
    setIdle();
    repeat (LAT - 1) @(negedge clk);
    checkOutput({name, "_rvalid"}, DATA_W'(rvalid), DATA_W'(1));
    checkOutput({name, "_rdata"}, rdata, exp);
  endtask

  // Pulse reset for one cycle, optionally hammer requests while busy, and count busy cycles
  task automatic resetAndCount(input bit drive_req, output int n);
    setIdle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (drive_req) begin
        applyStimulus(1'b1, 1'b1, 1'b1, '1, ADDR_W'(2), 16'hFFFF);
      end else begin
        @(negedge clk);
      end
    end
    setIdle();
  endtask

  // Reference model: word array, countdown of words left to clear, queue of due read results
  initial begin : model
    logic [DATA_W-1:0] old_w;
    logic [DATA_W-1:0] new_w;
    clear_left = DEPTH;
    cyc        = 0;
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
    exp_busy   = 1'b1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        clear_left = DEPTH;
        pend_q.delete();
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
      end else begin
        cyc++;
        if (clear_left > 0) begin
          model_mem[DEPTH - clear_left] = '0;
          clear_left--;
        end else if (cs) begin
          old_w = model_mem[addr];
          new_w = old_w;
          for (int i = 0; i < NB; i++) begin
            if (be[i]) new_w[i*8 +: 8] = wdata[i*8 +: 8];
          end
          if (rd) pend_q.push_back('{(RDW_MODE == 1 && wr) ? new_w : old_w, cyc + LAT - 1});
          if (wr) model_mem[addr] = new_w;
        end
        exp_rvalid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          exp_rvalid = 1'b1;
          exp_rdata  = pend_q[0].data;
          void'(pend_q.pop_front());
        end
      end
      exp_busy = (clear_left > 0);
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin : compare
    wait (started);
    forever begin
      @(negedge clk);
      #1;
      checkOutput("cyc_busy", DATA_W'(busy), DATA_W'(exp_busy));
      checkOutput("cyc_rvalid", DATA_W'(rvalid), DATA_W'(exp_rvalid));
      checkOutput("cyc_rdata", rdata, exp_rdata);
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin : stim
    int n;
    int vld [8];
    logic [DATA_W-1:0] dat [8];
    logic [DATA_W-1:0] bb_words [3];

    rst_n = 1'b0;
    setIdle();
    be    = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", rdata, '0);
    checkOutput("reset_rvalid", DATA_W'(rvalid), '0);
    checkOutput("reset_busy", DATA_W'(busy), DATA_W'(1));
    started = 1;

    $display("[TB] clear after reset release");
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("clear_busy_cycles", DATA_W'(n), DATA_W'(16));
    for (int a = 0; a < DEPTH; a++) begin
      readCheck("clear_word", ADDR_W'(a), '0);
    end

    $display("[TB] reset mid-clear");
    writeWord(ADDR_W'(6), 16'hBEEF, 2'b11);
    readCheck("word6_written", ADDR_W'(6), 16'hBEEF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    resetAndCount(1'b0, n);
    checkOutput("restart_busy_cycles", DATA_W'(n), DATA_W'(16));
    readCheck("word6_cleared", ADDR_W'(6), '0);

    $display("[TB] byte-lane write merge");
    writeWord(ADDR_W'(3), 16'hA5A5, 2'b11);
    writeWord(ADDR_W'(3), 16'h00FF, 2'b01);
    writeWord(ADDR_W'(3), 16'h7777, 2'b00);
    readCheck("lane_merge", ADDR_W'(3), 16'hA5FF);

    $display("[TB] read during write");
    writeWord(ADDR_W'(5), 16'h1111, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, ADDR_W'(5), 16'h2222);
    setIdle();
    repeat (LAT - 1) @(negedge clk);
    checkOutput("rdw_rvalid", DATA_W'(rvalid), DATA_W'(1));
    checkOutput("rdw_rdata", rdata, (RDW_MODE == 1) ? 16'h2222 : 16'h1111);
    readCheck("rdw_after", ADDR_W'(5), 16'h2222);
    writeWord(ADDR_W'(5), 16'h3344, 2'b11);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, ADDR_W'(5), 16'hAABB);
    setIdle();
    repeat (LAT - 1) @(negedge clk);
    checkOutput("rdw_partial", rdata, (RDW_MODE == 1) ? 16'hAA44 : 16'h3344);

    $display("[TB] requests while busy are dropped");
    writeWord(ADDR_W'(2), 16'h1234, 2'b11);
    resetAndCount(1'b1, n);
    checkOutput("busy_req_cycles", DATA_W'(n), DATA_W'(16));
    readCheck("busy_write_dropped", ADDR_W'(2), '0);

    $display("[TB] back-to-back reads");
    bb_words[0] = 16'h0A0A;
    bb_words[1] = 16'h1B1B;
    bb_words[2] = 16'h2C2C;
    for (int k = 0; k < 3; k++) writeWord(ADDR_W'(k), bb_words[k], 2'b11);
    for (int k = 0; k < 3 + LAT; k++) begin
      if (k < 3) applyStimulus(1'b1, 1'b1, 1'b0, '0, ADDR_W'(k), '0);
      else begin
        setIdle();
        @(negedge clk);
      end
      vld[k] = int'(rvalid);
      dat[k] = rdata;
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("b2b_rvalid", DATA_W'(vld[LAT - 1 + k]), DATA_W'(1));
      checkOutput("b2b_rdata", dat[LAT - 1 + k], bb_words[k]);
    end
    checkOutput("b2b_idle_rvalid", DATA_W'(vld[LAT + 2]), '0);
    checkOutput("b2b_hold_rdata", dat[LAT + 2], 16'h2C2C);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      if (k == 300) begin
        setIdle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      NB'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      end
    end
    setIdle();
    repeat (LAT + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
